i2c_cmd_sequencer: RTL and testbench
====================================

I2C_CMD_SEQUENCER -- requirements
Module: i2c_cmd_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, command FIFO entries; SHALL be a power of two, 2..16.
REQ-002 Parameter TIMEOUT_CYCLES, default 65535, maximum clk cycles one transaction may take from start until busy falls.
REQ-003 clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  FIFO can accept a command.
REQ-007 cmd_addr  input  7  target 7-bit I2C address.
REQ-008 cmd_rw  input  1  0 = write, 1 = read.
REQ-009 cmd_wdata  input  8  write byte; ignored for reads.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  consumer accepts response.
REQ-012 rsp_rdata  output  8  read byte; 8'h00 for writes.
REQ-013 rsp_ack_err  output  1  master reported ack_error.
REQ-014 rsp_timeout  output  1  transaction exceeded TIMEOUT_CYCLES.
REQ-015 m_start  output  1  start request to i2c_master.
REQ-016 m_addr / m_rw / m_data_in  output  7/1/8  master command fields.
REQ-017 m_data_out / m_ack_error / m_busy  input  8/1/1  master results and status.
REQ-018 fifo_level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-019 A command SHALL be pushed when cmd_valid && cmd_ready; cmd_ready SHALL be 1 exactly when fifo_level < FIFO_DEPTH.
REQ-020 FIFO pointers SHALL wrap modulo FIFO_DEPTH; a simultaneous push and pop SHALL leave fifo_level unchanged.
REQ-021 The FSM SHALL have states IDLE, LAUNCH, WAIT_DONE and RESP.
REQ-022 IDLE: if fifo_level > 0, pop the head entry into registered m_addr/m_rw/m_data_in and go to LAUNCH on the next cycle.
REQ-023 LAUNCH: m_start = 1; on the first cycle with m_busy = 1, go to WAIT_DONE, with m_start = 0 from that cycle on.
REQ-024 WAIT_DONE: on m_busy = 0, capture m_data_out (forced to 8'h00 when m_rw = 0) and m_ack_error into the response registers, then go to RESP.
REQ-025 Timeout counter: clears on entry to LAUNCH and increments each cycle in LAUNCH/WAIT_DONE.
REQ-026 When the counter reaches TIMEOUT_CYCLES, SHALL go to RESP with rsp_timeout = 1, rsp_ack_err = 0, rsp_rdata = 8'h00, and m_start = 0.
REQ-027 RESP: rsp_valid = 1 with stable fields until rsp_ready; on handshake go to IDLE.
REQ-028 Backpressure: the next command SHALL NOT launch until the response is consumed, so at most one transaction is outstanding.
REQ-029 m_addr/m_rw/m_data_in SHALL hold stable from LAUNCH entry until RESP exit.
REQ-030 Minimum latency from push into an empty FIFO to m_start = 1 SHALL be 2 cycles.
REQ-031 m_start SHALL be asserted only in LAUNCH.

Reset
REQ-032 On rst_n = 0, immediately: FSM = IDLE; FIFO empty (fifo_level = 0); cmd_ready = 1 after release; m_start = 0; m_addr = 0; m_rw = 0; m_data_in = 0; rsp_valid = 0; rsp_rdata = 0; rsp_ack_err = 0; rsp_timeout = 0; counter = 0.
REQ-033 Reset mid-transaction SHALL drop m_start at once and discard queued commands and any pending response.

Verification
REQ-034 Write: push {addr 7'h51, rw 0, wdata 8'h3C} to the i2c_master/i2c_slave pair (slave own_addr 7'h51) -> m_start pulses until busy, then one response: rdata 8'h00, ack_err 0, timeout 0.
REQ-035 Read: push {7'h51, rw 1} after the write -> response rdata equals the byte returned by the slave, ack_err 0.
REQ-036 NACK: push {7'h22, rw 0, 8'hA5} -> response ack_err 1, timeout 0.
REQ-037 Full/backpressure: hold rsp_ready = 0 and push 5 commands with FIFO_DEPTH = 4 -> cmd_ready = 0 when fifo_level = 4; first response holds stable; releasing rsp_ready drains all 5 commands in order.
REQ-038 Timeout: tie m_busy = 1 with TIMEOUT_CYCLES = 100 -> response with timeout 1 exactly 100 cycles after LAUNCH entry, m_start = 0.
REQ-039 Reset: assert rst_n = 0 during WAIT_DONE with 2 queued commands -> all outputs take REQ-032 values, no response is issued, fifo_level = 0.

Source files
------------

// File: rtl/i2c_cmd_sequencer_if.sv
// Command, response and i2c_master-facing signals of the I2C command sequencer.
// The slave modport is the sequencer's view; master is the view of whatever drives it.
interface i2c_cmd_sequencer_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    // Command push side
    logic          cmd_valid;
    logic          cmd_ready;
    logic [6:0]    cmd_addr;
    logic          cmd_rw;
    logic [7:0]    cmd_wdata;

    // Response side
    logic          rsp_valid;
    logic          rsp_ready;
    logic [7:0]    rsp_rdata;
    logic          rsp_ack_err;
    logic          rsp_timeout;

    // i2c_master command and status
    logic          m_start;
    logic [6:0]    m_addr;
    logic          m_rw;
    logic [7:0]    m_data_in;
    logic [7:0]    m_data_out;
    logic          m_ack_error;
    logic          m_busy;

    logic [LW-1:0] fifo_level;

    modport slave (
        input  cmd_valid, cmd_addr, cmd_rw, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_ack_err, rsp_timeout,
        input  rsp_ready,
        output m_start, m_addr, m_rw, m_data_in,
        input  m_data_out, m_ack_error, m_busy,
        output fifo_level
    );

    modport master (
        output cmd_valid, cmd_addr, cmd_rw, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_ack_err, rsp_timeout,
        output rsp_ready,
        input  m_start, m_addr, m_rw, m_data_in,
        output m_data_out, m_ack_error, m_busy,
        input  fifo_level
    );
endinterface

// File: rtl/i2c_cmd_sequencer.sv
// Queues I2C commands in a small FIFO and runs them one at a time through an
// i2c_master, returning one response per command with ack-error and timeout status.
module i2c_cmd_sequencer #(
    parameter int FIFO_DEPTH     = 4,      // power of two, 2..16
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    i2c_cmd_sequencer_if.slave bus
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [AW:0]   DEPTH_L  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LAUNCH    = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;
    localparam logic [1:0] ST_RESP      = 2'd3;

    typedef struct packed {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] wdata;
    } cmd_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    cmd_t          fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q,  level_d;

    logic cmd_ready;
    logic push;
    logic pop;
    cmd_t cmd_in;
    cmd_t head;

    assign cmd_ready = (level_q < DEPTH_L);
    assign push      = bus.cmd_valid && cmd_ready;
    assign cmd_in    = '{addr: bus.cmd_addr, rw: bus.cmd_rw, wdata: bus.cmd_wdata};
    assign head      = fifo_mem_q[rd_ptr_q];

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + (AW + 1)'(1);
            2'b01:   level_d = level_q - (AW + 1)'(1);
            default: level_d = level_q;
        endcase
    end

    // NOTE: storage is not reset; an entry is only read after a push has written it.
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= cmd_in;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // ------------------------------------------------------------------
    // Transaction FSM
    // ------------------------------------------------------------------
    logic [1:0]    state_q,     state_d;
    logic [6:0]    m_addr_q,    m_addr_d;
    logic          m_rw_q,      m_rw_d;
    logic [7:0]    m_data_q,    m_data_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic [7:0]    rsp_rdata_q, rsp_rdata_d;
    logic          rsp_ack_q,   rsp_ack_d;
    logic          rsp_to_q,    rsp_to_d;

    logic [CW-1:0] cnt_inc;
    logic          cnt_expired;

    assign cnt_inc     = cnt_q + CW'(1);
    assign cnt_expired = (cnt_inc == TO_LIMIT);

    always_comb begin
        state_d     = state_q;
        m_addr_d    = m_addr_q;
        m_rw_d      = m_rw_q;
        m_data_d    = m_data_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_ack_d   = rsp_ack_q;
        rsp_to_d    = rsp_to_q;
        pop         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (level_q != '0) begin
                    pop      = 1'b1;
                    m_addr_d = head.addr;
                    m_rw_d   = head.rw;
                    m_data_d = head.wdata;
                    cnt_d    = '0;
                    state_d  = ST_LAUNCH;
                end
            end

            ST_LAUNCH: begin
                cnt_d = cnt_inc;
                if (cnt_expired) begin
                    rsp_rdata_d = 8'h00;
                    rsp_ack_d   = 1'b0;
                    rsp_to_d    = 1'b1;
                    state_d     = ST_RESP;
                end else if (bus.m_busy) begin
                    state_d = ST_WAIT_DONE;
                end
            end

            ST_WAIT_DONE: begin
                // A finished transfer wins over a timeout landing on the same cycle.
                if (!bus.m_busy) begin
                    rsp_rdata_d = m_rw_q ? bus.m_data_out : 8'h00;
                    rsp_ack_d   = bus.m_ack_error;
                    rsp_to_d    = 1'b0;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_expired) begin
                        rsp_rdata_d = 8'h00;
                        rsp_ack_d   = 1'b0;
                        rsp_to_d    = 1'b1;
                        state_d     = ST_RESP;
                    end
                end
            end

            ST_RESP: begin
                if (bus.rsp_ready) state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            m_addr_q    <= '0;
            m_rw_q      <= 1'b0;
            m_data_q    <= '0;
            cnt_q       <= '0;
            rsp_rdata_q <= '0;
            rsp_ack_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_addr_q    <= m_addr_d;
            m_rw_q      <= m_rw_d;
            m_data_q    <= m_data_d;
            cnt_q       <= cnt_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_ack_q   <= rsp_ack_d;
            rsp_to_q    <= rsp_to_d;
        end
    end

    // Decoded from the registered state, so reset drops m_start immediately.
    assign bus.m_start     = (state_q == ST_LAUNCH);
    assign bus.m_addr      = m_addr_q;
    assign bus.m_rw        = m_rw_q;
    assign bus.m_data_in   = m_data_q;

    assign bus.rsp_valid   = (state_q == ST_RESP);
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_ack_err = rsp_ack_q;
    assign bus.rsp_timeout = rsp_to_q;

    assign bus.cmd_ready   = cmd_ready;
    assign bus.fifo_level  = level_q;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer with a behavioural i2c_master/slave model
// (slave address 7'h51 holds one byte; other addresses NACK).
module tb_i2c_cmd_sequencer;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 100;

    logic clk;
    logic rst_n;
    logic stuck_busy;

    int n_checks;
    int n_fail;

    i2c_cmd_sequencer_if #(.FIFO_DEPTH(DEPTH)) bus ();

    i2c_cmd_sequencer #(
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural i2c_master + slave ----------------
    logic [7:0] slave_mem;
    logic [6:0] lat_addr;
    logic       lat_rw;
    logic [7:0] lat_data;
    int         bcnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.m_busy      <= 1'b0;
            bus.m_data_out  <= 8'h00;
            bus.m_ack_error <= 1'b0;
            bcnt            <= 0;
            slave_mem       <= 8'h00;
            lat_addr        <= 7'h00;
            lat_rw          <= 1'b0;
            lat_data        <= 8'h00;
        end else if (stuck_busy) begin
            bus.m_busy <= 1'b1;
            bcnt       <= 0;
        end else if (bus.m_busy) begin
            if (bcnt == 0) begin
                bus.m_busy      <= 1'b0;
                bus.m_ack_error <= (lat_addr != 7'h51);
                // Writes return garbage on data_out; the sequencer must zero it.
                bus.m_data_out  <= !lat_rw ? 8'hEE : ((lat_addr == 7'h51) ? slave_mem : 8'hFF);
                if (lat_addr == 7'h51 && !lat_rw) slave_mem <= lat_data;
            end else begin
                bcnt <= bcnt - 1;
            end
        end else if (bus.m_start) begin
            bus.m_busy <= 1'b1;
            bcnt       <= 5;
            lat_addr   <= bus.m_addr;
            lat_rw     <= bus.m_rw;
            lat_data   <= bus.m_data_in;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [6:0] addr, input logic rw, input logic [7:0] wdata);
        int n;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = addr;
        bus.cmd_rw    = rw;
        bus.cmd_wdata = wdata;
        n = 0;
        while (!bus.cmd_ready && n < 400) begin
            tick();
            n++;
        end
        check("push_ready", bus.cmd_ready, 1'b1);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int limit, output int cycles);
        int n;
        n = 0;
        while (!bus.rsp_valid && n < limit) begin
            tick();
            n++;
        end
        cycles = n;
        check("rsp_arrived", bus.rsp_valid, 1'b1);
    endtask

    task automatic consume();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("rsp_dropped", bus.rsp_valid, 1'b0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_level"},  32'(bus.fifo_level), 0);
        check({tag, "_start"},  bus.m_start,     1'b0);
        check({tag, "_maddr"},  bus.m_addr,      7'h00);
        check({tag, "_mrw"},    bus.m_rw,        1'b0);
        check({tag, "_mdata"},  bus.m_data_in,   8'h00);
        check({tag, "_rvalid"}, bus.rsp_valid,   1'b0);
        check({tag, "_rdata"},  bus.rsp_rdata,   8'h00);
        check({tag, "_ackerr"}, bus.rsp_ack_err, 1'b0);
        check({tag, "_tmo"},    bus.rsp_timeout, 1'b0);
    endtask

    typedef struct packed {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        logic       exp_ack;
        logic       exp_to;
    } vec_t;

    vec_t vecs [6];

    // ---------------- main sequence ----------------
    initial begin
        int   cyc;
        logic stable;
        logic [7:0] h_rdata;
        logic h_ack;
        logic h_to;
        logic [6:0] h_addr;

        vecs[0] = '{7'h51, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b0};  // write
        vecs[1] = '{7'h51, 1'b1, 8'h00, 8'h3C, 1'b0, 1'b0};  // read back
        vecs[2] = '{7'h22, 1'b0, 8'hA5, 8'h00, 1'b1, 1'b0};  // NACK write
        vecs[3] = '{7'h51, 1'b0, 8'h7E, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{7'h51, 1'b1, 8'h99, 8'h7E, 1'b0, 1'b0};  // wdata ignored on read
        vecs[5] = '{7'h22, 1'b1, 8'h00, 8'hFF, 1'b1, 1'b0};  // NACK read

        n_checks      = 0;
        n_fail        = 0;
        stuck_busy    = 1'b0;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = 7'h00;
        bus.cmd_rw    = 1'b0;
        bus.cmd_wdata = 8'h00;
        bus.rsp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        check_reset_vals("reset");
        check("reset_ready", bus.cmd_ready, 1'b1);

        // Minimum launch latency: m_start two cycles after the push cycle.
        push(7'h51, 1'b0, 8'h5A);
        check("lat_start_c1", bus.m_start, 1'b0);
        tick();
        check("lat_start_c2", bus.m_start, 1'b1);
        check("lat_maddr",    bus.m_addr,    7'h51);
        check("lat_mdata",    bus.m_data_in, 8'h5A);
        wait_rsp(200, cyc);
        check("lat_rdata", bus.rsp_rdata, 8'h00);
        consume();

        // Table-driven single transactions.
        foreach (vecs[i]) begin
            push(vecs[i].addr, vecs[i].rw, vecs[i].wdata);
            wait_rsp(200, cyc);
            check($sformatf("vec%0d_rdata", i),  bus.rsp_rdata,   vecs[i].exp_rdata);
            check($sformatf("vec%0d_ackerr", i), bus.rsp_ack_err, vecs[i].exp_ack);
            check($sformatf("vec%0d_tmo", i),    bus.rsp_timeout, vecs[i].exp_to);
            check($sformatf("vec%0d_maddr", i),  bus.m_addr,      vecs[i].addr);
            check($sformatf("vec%0d_mstart", i), bus.m_start,     1'b0);
            consume();
        end

        // Backpressure: five commands with responses held off.
        push(7'h51, 1'b0, 8'h11);
        push(7'h51, 1'b1, 8'h00);
        check("bp_pushpop_level", 32'(bus.fifo_level), 1);
        push(7'h51, 1'b0, 8'h22);
        push(7'h51, 1'b1, 8'h00);
        push(7'h22, 1'b0, 8'h33);
        check("bp_full_level", 32'(bus.fifo_level), 4);
        check("bp_full_ready", bus.cmd_ready, 1'b0);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 7'h51;
        bus.cmd_rw    = 1'b0;
        bus.cmd_wdata = 8'h44;
        repeat (3) tick();
        bus.cmd_valid = 1'b0;
        check("bp_blocked_level", 32'(bus.fifo_level), 4);

        wait_rsp(200, cyc);
        h_rdata = bus.rsp_rdata;
        h_ack   = bus.rsp_ack_err;
        h_to    = bus.rsp_timeout;
        h_addr  = bus.m_addr;
        stable  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (!bus.rsp_valid || bus.rsp_rdata !== h_rdata || bus.rsp_ack_err !== h_ack ||
                bus.rsp_timeout !== h_to || bus.m_addr !== h_addr || bus.m_start !== 1'b0)
                stable = 1'b0;
        end
        check("bp_rsp_hold",  stable, 1'b1);
        check("bp_no_launch", 32'(bus.fifo_level), 4);
        check("bp0_rdata", bus.rsp_rdata,   8'h00);
        check("bp0_ackerr", bus.rsp_ack_err, 1'b0);
        consume();
        wait_rsp(200, cyc);
        check("bp1_rdata", bus.rsp_rdata, 8'h11);
        check("bp1_maddr", bus.m_addr,    7'h51);
        consume();
        wait_rsp(200, cyc);
        check("bp2_rdata", bus.rsp_rdata,  8'h00);
        check("bp2_mdata", bus.m_data_in,  8'h22);
        consume();
        wait_rsp(200, cyc);
        check("bp3_rdata", bus.rsp_rdata, 8'h22);
        consume();
        wait_rsp(200, cyc);
        check("bp4_ackerr", bus.rsp_ack_err, 1'b1);
        check("bp4_maddr",  bus.m_addr,      7'h22);
        consume();
        check("bp_drained", 32'(bus.fifo_level), 0);

        // Timeout: master never releases busy.
        stuck_busy = 1'b1;
        push(7'h51, 1'b1, 8'h00);
        tick();
        check("to_launch", bus.m_start, 1'b1);
        wait_rsp(300, cyc);
        check("to_cycles", cyc,             TIMEOUT);
        check("to_flag",   bus.rsp_timeout, 1'b1);
        check("to_ackerr", bus.rsp_ack_err, 1'b0);
        check("to_rdata",  bus.rsp_rdata,   8'h00);
        check("to_mstart", bus.m_start,     1'b0);
        consume();
        stuck_busy = 1'b0;
        repeat (4) tick();

        // Reset during WAIT_DONE with two commands queued.
        push(7'h51, 1'b0, 8'h01);
        push(7'h51, 1'b0, 8'h02);
        push(7'h51, 1'b1, 8'h03);
        cyc = 0;
        while (!(bus.m_busy && !bus.m_start) && cyc < 50) begin
            tick();
            cyc++;
        end
        check("rst_in_wait", bus.m_busy && !bus.m_start, 1'b1);
        check("rst_queued",  32'(bus.fifo_level), 2);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        stable = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.rsp_valid || bus.m_start || bus.fifo_level != '0) stable = 1'b0;
        end
        check("rst_quiet", stable, 1'b1);
        check("rst_ready", bus.cmd_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
